// File: rtl/trsq8_timer.sv
// TRSQ8 8-bit interval timer: prescaler, compare-match with auto-reload or one-shot, sticky MF.
// Optional PWM output and DUTY register enabled by defining TRSQ8_TIMER_PWM_EN.
module trsq8_timer #(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter logic [7:0] RESET_CMP = 8'hFF
) (
  input  logic       clk_ip,
  input  logic       reset_ip,
  input  logic [7:0] addr_ip,
  input  logic [7:0] data_ip,
  input  logic       wr_en_ip,
  input  logic       rd_en_ip,
  output logic [7:0] data_op,
  output logic       irq_op,
  output logic       pwm_op
);

  localparam logic [7:0] OffCtrl = 8'd0;
  localparam logic [7:0] OffCmp  = 8'd1;
  localparam logic [7:0] OffCnt  = 8'd2;
  localparam logic [7:0] OffStat = 8'd3;
  localparam logic [7:0] OffDuty = 8'd4;

  logic       en_q, en_d;
  logic       arld_q, arld_d;
  logic       ien_q, ien_d;
  logic [2:0] psel_q, psel_d;
  logic [7:0] cmp_q, cmp_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mf_q, mf_d;
  logic [6:0] ps_q, ps_d;

  logic [7:0] off;
  logic [7:0] ps_lim;
  logic       wr_ctrl, wr_cmp, wr_cnt, wr_stat;
  logic       tick, match;

  // Offset arithmetic is modulo 256, so a window near the top of the map still decodes.
  assign off     = addr_ip - BASE_ADDR;
  assign wr_ctrl = wr_en_ip & (off == OffCtrl);
  assign wr_cmp  = wr_en_ip & (off == OffCmp);
  assign wr_cnt  = wr_en_ip & (off == OffCnt);
  assign wr_stat = wr_en_ip & (off == OffStat);

  assign ps_lim = (8'd1 << psel_q) - 8'd1;
  assign tick   = en_q & ({1'b0, ps_q} == ps_lim);
  // A CNT write in the same cycle suppresses match evaluation on the old count.
  assign match  = tick & ~wr_cnt & (cnt_q == cmp_q);

  always_comb begin
    en_d   = en_q;
    arld_d = arld_q;
    ien_d  = ien_q;
    psel_d = psel_q;
    cmp_d  = cmp_q;
    cnt_d  = cnt_q;
    mf_d   = mf_q;
    ps_d   = ps_q + 7'd1;

    if (wr_ctrl) begin
      en_d   = data_ip[0];
      arld_d = data_ip[1];
      ien_d  = data_ip[2];
      psel_d = data_ip[6:4];
    end else if (match && !arld_q) begin
      en_d = 1'b0;
    end

    if (wr_ctrl || !en_q || tick) begin
      ps_d = 7'd0;
    end

    if (wr_cmp) begin
      cmp_d = data_ip;
    end

    if (wr_cnt) begin
      cnt_d = data_ip;
    end else if (tick) begin
      cnt_d = match ? 8'd0 : cnt_q + 8'd1;
    end

    if (match) begin
      mf_d = 1'b1;
    end else if (wr_stat && data_ip[0]) begin
      mf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_ip) begin
    if (reset_ip) begin
      en_q   <= 1'b0;
      arld_q <= 1'b0;
      ien_q  <= 1'b0;
      psel_q <= 3'd0;
      cmp_q  <= RESET_CMP;
      cnt_q  <= 8'd0;
      mf_q   <= 1'b0;
      ps_q   <= 7'd0;
    end else begin
      en_q   <= en_d;
      arld_q <= arld_d;
      ien_q  <= ien_d;
      psel_q <= psel_d;
      cmp_q  <= cmp_d;
      cnt_q  <= cnt_d;
      mf_q   <= mf_d;
      ps_q   <= ps_d;
    end
  end

  assign irq_op = mf_q & ien_q;

`ifdef TRSQ8_TIMER_PWM_EN
  logic [7:0] duty_q;
  logic       pwm_q;

  always_ff @(posedge clk_ip) begin
    if (reset_ip) begin
      duty_q <= 8'd0;
      pwm_q  <= 1'b0;
    end else begin
      if (wr_en_ip && (off == OffDuty)) begin
        duty_q <= data_ip;
      end
      pwm_q <= en_q & (cnt_q < duty_q);
    end
  end

  assign pwm_op = pwm_q;
`else
  assign pwm_op = 1'b0;
`endif

  always_comb begin
    data_op = 8'h00;
    if (rd_en_ip) begin
      case (off)
        OffCtrl: data_op = {1'b0, psel_q, 1'b0, ien_q, arld_q, en_q};
        OffCmp:  data_op = cmp_q;
        OffCnt:  data_op = cnt_q;
        OffStat: data_op = {7'd0, mf_q};
`ifdef TRSQ8_TIMER_PWM_EN
        OffDuty: data_op = duty_q;
`endif
        default: data_op = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_trsq8_timer.sv
// Directed bench for trsq8_timer; expectations queued as a scoreboard and popped on sampling.
module tb_trsq8_timer;

  localparam logic [7:0] Base = 8'h10;

  logic       clk_ip = 1'b0;
  logic       reset_ip;
  logic [7:0] addr_ip;
  logic [7:0] data_ip;
  logic       wr_en_ip;
  logic       rd_en_ip;
  logic [7:0] data_op;
  logic       irq_op;
  logic       pwm_op;

  trsq8_timer #(
    .BASE_ADDR(8'h10),
    .RESET_CMP(8'hFF)
  ) dut (
    .clk_ip  (clk_ip),
    .reset_ip(reset_ip),
    .addr_ip (addr_ip),
    .data_ip (data_ip),
    .wr_en_ip(wr_en_ip),
    .rd_en_ip(rd_en_ip),
    .data_op (data_op),
    .irq_op  (irq_op),
    .pwm_op  (pwm_op)
  );

  always #5 clk_ip = ~clk_ip;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  exp_q[$];
  string       tag_q[$];

  task automatic push(input string tag, input logic [7:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    logic [7:0] e;
    string      t;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty: got %h want <queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: got %h want %h", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_ip);
    #1;
  endtask

  task automatic wr(input logic [7:0] o, input logic [7:0] d);
    addr_ip  = Base + o;
    data_ip  = d;
    wr_en_ip = 1'b1;
    step();
    wr_en_ip = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] o, input logic [7:0] e);
    push(tag, e);
    addr_ip  = Base + o;
    rd_en_ip = 1'b1;
    #1;
    pop_check(data_op);
    rd_en_ip = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic e);
    push(tag, {7'd0, e});
    pop_check({7'd0, irq_op});
  endtask

  int unsigned pwm_hi;

  initial begin
    reset_ip = 1'b1;
    addr_ip  = 8'h00;
    data_ip  = 8'h00;
    wr_en_ip = 1'b0;
    rd_en_ip = 1'b0;
    step();
    step();
    reset_ip = 1'b0;

    // Reset state and read rule
    chk_rd("rst_ctrl", 8'd0, 8'h00);
    chk_rd("rst_cmp", 8'd1, 8'hFF);
    chk_rd("rst_cnt", 8'd2, 8'h00);
    chk_rd("rst_stat", 8'd3, 8'h00);
    step();
    chk_rd("rst_plus4", 8'd4, 8'h00);
    chk_rd("rd_plus5", 8'd5, 8'h00);
    push("rd_en_low", 8'h00);
    addr_ip = Base + 8'd1;
    #1;
    pop_check(data_op);
    chk_irq("rst_irq", 1'b0);
    push("rst_pwm", 8'h00);
    pop_check({7'd0, pwm_op});

    // Auto-reload: CMP=3, EN|ARLD|IEN, PSEL=0
    wr(8'd1, 8'd3);
    wr(8'd0, 8'h07);
    chk_rd("ar_cnt0", 8'd2, 8'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_rd($sformatf("ar_cnt%0d", i), 8'd2, 8'(i % 4));
      chk_irq($sformatf("ar_irq%0d", i), i == 4);
    end
    chk_rd("ar_mf", 8'd3, 8'h01);
    wr(8'd3, 8'h01);
    chk_irq("ar_irq_clr", 1'b0);
    for (int k = 6; k <= 8; k++) begin
      step();
      chk_irq($sformatf("ar_irq_re%0d", k), k == 8);
    end

    // STAT clear colliding with match: set wins
    wr(8'd3, 8'h01);
    chk_rd("col_mf_cleared", 8'd3, 8'h00);
    step();
    step();
    wr(8'd3, 8'h01);
    chk_rd("col_mf_setwins", 8'd3, 8'h01);
    chk_rd("col_cnt_match", 8'd2, 8'h00);

    // CNT write on a tick cycle: write wins, no increment
    wr(8'd2, 8'h05);
    chk_rd("col_cnt_wr", 8'd2, 8'h05);

    // Prescaler PSEL=2, one-shot, CMP=1
    wr(8'd0, 8'h00);
    wr(8'd3, 8'h01);
    wr(8'd2, 8'h00);
    wr(8'd1, 8'h01);
    wr(8'd0, 8'h21);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk_rd($sformatf("os_cnt%0d", c), 8'd2, (c >= 4 && c < 8) ? 8'd1 : 8'd0);
      chk_irq($sformatf("os_irq%0d", c), 1'b0);
    end
    chk_rd("os_ctrl", 8'd0, 8'h20);
    chk_rd("os_mf", 8'd3, 8'h01);

    // CMP written below CNT: wrap through FF before matching
    wr(8'd3, 8'h01);
    wr(8'd2, 8'd9);
    wr(8'd1, 8'd2);
    wr(8'd0, 8'h03);
    chk_rd("wr_cnt_start", 8'd2, 8'd9);
    for (int k = 1; k <= 250; k++) begin
      step();
      if (k == 246) chk_rd("wr_cnt_ff", 8'd2, 8'hFF);
      if (k == 247) chk_rd("wr_cnt_00", 8'd2, 8'h00);
      if (k == 249) begin
        chk_rd("wr_cnt_02", 8'd2, 8'h02);
        chk_rd("wr_mf_pre", 8'd3, 8'h00);
      end
    end
    chk_rd("wr_cnt_after", 8'd2, 8'h00);
    chk_rd("wr_mf_after", 8'd3, 8'h01);

    // Reset mid-count
    wr(8'd1, 8'd20);
    wr(8'd0, 8'h07);
    wr(8'd2, 8'd7);
    chk_rd("mid_cnt", 8'd2, 8'd7);
    chk_rd("mid_mf", 8'd3, 8'h01);
    chk_irq("mid_irq", 1'b1);
    reset_ip = 1'b1;
    step();
    chk_rd("mid_rst_cnt", 8'd2, 8'h00);
    chk_rd("mid_rst_mf", 8'd3, 8'h00);
    chk_rd("mid_rst_ctrl", 8'd0, 8'h00);
    chk_irq("mid_rst_irq", 1'b0);
    reset_ip = 1'b0;
    step();
    step();
    chk_rd("mid_post_cnt", 8'd2, 8'h00);

`ifdef TRSQ8_TIMER_PWM_EN
    wr(8'd1, 8'd9);
    wr(8'd4, 8'd3);
    chk_rd("pwm_duty", 8'd4, 8'd3);
    wr(8'd0, 8'h03);
    for (int i = 0; i < 12; i++) step();
    pwm_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_op) pwm_hi++;
      step();
    end
    push("pwm_high_count", 8'd6);
    pop_check(8'(pwm_hi));
`else
    wr(8'd4, 8'h5A);
    chk_rd("nopwm_plus4", 8'd4, 8'h00);
    wr(8'd1, 8'd9);
    wr(8'd0, 8'h03);
    pwm_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (pwm_op) pwm_hi++;
      step();
    end
    push("nopwm_high_count", 8'd0);
    pop_check(8'(pwm_hi));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
